// File: rtl/segment_ex_mem_burst.sv
// EX/MEM pipeline segment with stall/flush handshake and a beat sequencer that
// moves R-lane vector loads/stores through a P-lane data-memory port.
module segment_ex_mem_burst #(
   parameter int I = 32,
   parameter int N = 8,
   parameter int R = 6,
   parameter int P = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ValidE,
   input  logic                FlushE,
   input  logic                StallM,
   input  logic                RegWriteE,
   input  logic                MemtoRegE,
   input  logic                MemWriteE,
   input  logic                FlagsWriteE,
   input  logic                LDFlagE,
   input  logic [1:0]          ALUFlagsE,
   input  logic [1:0]          VSIFlagE,
   input  logic [3:0]          WA3E,
   input  logic [I-1:0]        AddressE,
   input  logic [R-1:0][N-1:0] ALUOutputE,
   input  logic [R-1:0][N-1:0] WriteDataE,
   input  logic                MemReady,
   input  logic [P-1:0][N-1:0] MemRdata,
   output logic                StallE,
   output logic                ValidM,
   output logic                RegWriteM,
   output logic                MemtoRegM,
   output logic                MemWriteM,
   output logic                FlagsWriteM,
   output logic                LDFlagM,
   output logic [1:0]          ALUFlagsM,
   output logic [1:0]          VSIFlagM,
   output logic [3:0]          WA3M,
   output logic [I-1:0]        AddressM,
   output logic [R-1:0][N-1:0] ALUOutputM,
   output logic [R-1:0][N-1:0] WriteDataM,
   output logic [R-1:0][N-1:0] LoadDataM,
   output logic                MemBeatValid,
   output logic                MemBeatWe,
   output logic [I-1:0]        MemBeatAddr,
   output logic [P-1:0][N-1:0] MemBeatData,
   output logic [((R/P) > 1 ? $clog2(R/P) : 1)-1:0] MemBeatIdx,
   output logic                MemBeatLast
);
   localparam int B = R / P;
   localparam int K = (B > 1) ? $clog2(B) : 1;

   typedef enum logic [1:0] {EMPTY, BEAT, HOLD} state_t;

   state_t                     state;
   logic [K-1:0]               k;
   // Beat-major views of the lane vectors so beat k is a plain array index.
   logic [B-1:0][P-1:0][N-1:0] ld_beats;
   logic [B-1:0][P-1:0][N-1:0] wd_beats;
   logic                       advance;

   assign wd_beats     = WriteDataM;
   assign LoadDataM    = ld_beats;
   assign StallE       = (state == BEAT) | ((state == HOLD) & StallM);
   assign advance      = !StallE;
   assign ValidM       = (state == HOLD);
   assign MemBeatValid = (state == BEAT);
   assign MemBeatWe    = MemWriteM;
   assign MemBeatIdx   = k;
   assign MemBeatLast  = (k == K'(B - 1));
   assign MemBeatAddr  = AddressM + (I'(k) * I'(P));
   assign MemBeatData  = wd_beats[k];

   always_ff @(negedge clk) begin
      if (!reset) begin
         state       <= EMPTY;
         k           <= '0;
         RegWriteM   <= 1'b0;
         MemtoRegM   <= 1'b0;
         MemWriteM   <= 1'b0;
         FlagsWriteM <= 1'b0;
         LDFlagM     <= 1'b0;
         ALUFlagsM   <= '0;
         VSIFlagM    <= '0;
         WA3M        <= '0;
         AddressM    <= '0;
         ALUOutputM  <= '0;
         WriteDataM  <= '0;
         ld_beats    <= '0;
      end else if (advance) begin
         if (ValidE && !FlushE) begin
            RegWriteM   <= RegWriteE;
            MemtoRegM   <= MemtoRegE;
            MemWriteM   <= MemWriteE;
            FlagsWriteM <= FlagsWriteE;
            LDFlagM     <= LDFlagE;
            ALUFlagsM   <= ALUFlagsE;
            VSIFlagM    <= VSIFlagE;
            WA3M        <= WA3E;
            AddressM    <= AddressE;
            ALUOutputM  <= ALUOutputE;
            WriteDataM  <= WriteDataE;
            ld_beats    <= '0;
            k           <= '0;
            state       <= (MemWriteE | MemtoRegE) ? BEAT : HOLD;
         end else begin
            // Bubble: kill side-effecting controls, leave data fields stale.
            state       <= EMPTY;
            RegWriteM   <= 1'b0;
            MemtoRegM   <= 1'b0;
            MemWriteM   <= 1'b0;
            FlagsWriteM <= 1'b0;
            LDFlagM     <= 1'b0;
         end
      end else if (state == BEAT && MemReady) begin
         if (MemtoRegM) ld_beats[k] <= MemRdata;
         if (MemBeatLast) begin
            state <= HOLD;
            k     <= '0;
         end else begin
            k     <= k + K'(1);
         end
      end
   end

endmodule

// File: doc/segment_ex_mem_burst.md
# segment_ex_mem_burst

Parametrised EX/MEM pipeline segment for the vector CPU. It latches an R-lane × N-bit execute result and its control fields, like the plain EX/MEM segment. It adds stall/flush handshaking and a memory-beat sequencer that moves vector loads/stores through a P-lane-wide data-memory port over R/P beats, assembling load data lane-wise. It sits between the vector ALU (EX) and the MEM/WB segment, and is the only master of the data-memory port.

## Interface
- I, 32, address width
- N, 8, lane width (bits)
- R, 6, lane count
- P, 2, lanes per memory beat; R % P == 0, 1 ≤ P ≤ R; B = R/P beats, K = max(1,$clog2(B)) counter bits
- clk  in  1  clock; all state updates on falling edge
- reset  in  1  synchronous, active-low (sampled on falling edge of clk)
- ValidE  in  1  EX holds a real instruction
- FlushE  in  1  replace incoming entry with bubble
- StallM  in  1  downstream (MEM/WB) cannot accept
- RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE, LDFlagE  in  1 each  control fields
- ALUFlagsE, VSIFlagE  in  2 each  flag fields
- WA3E  in  4  destination register
- AddressE  in  I  base element address
- ALUOutputE, WriteDataE  in  R×N each  lane vectors
- MemReady  in  1  memory accepts current beat
- MemRdata  in  P×N  read lanes for current beat (valid when MemReady)
- StallE  out  1  segment cannot capture this cycle
- ValidM  out  1  entry complete and presented to MEM/WB
- RegWriteM … ALUOutputM, WriteDataM  out  same widths  registered copies of the E fields
- LoadDataM  out  R×N  assembled load vector
- MemBeatValid  out  1  beat request active
- MemBeatWe  out  1  beat is a write (= MemWriteM)
- MemBeatAddr  out  I  AddressM + k·P, mod 2^I
- MemBeatData  out  P×N  WriteDataM lanes [k·P +: P]
- MemBeatIdx  out  K  current beat k
- MemBeatLast  out  1  k == B−1

## Operation
- States: EMPTY, BEAT, HOLD; counter k (K bits).
- StallE = (state==BEAT) | (state==HOLD & StallM). Advance = !StallE.
- On advance:
  - ValidE & !FlushE: capture all E fields; LoadDataM ← 0; k ← 0.
    - MemWriteE|MemtoRegE → BEAT.
    - Otherwise → HOLD.
  - Otherwise (no ValidE, or FlushE): → EMPTY. RegWriteM, MemtoRegM, MemWriteM, FlagsWriteM, LDFlagM ← 0; data fields retain value.
- FlushE is ignored while StallE=1; an in-progress burst is never aborted except by reset.
- BEAT:
  - MemBeatValid=1.
  - On MemReady: if MemtoRegM, LoadDataM lanes [k·P +: P] ← MemRdata.
  - On MemReady: if k==B−1 → HOLD, k ← 0; else k ← k+1.
  - MemReady=0: hold all.
- HOLD: ValidM=1; leaves only via advance.
- EMPTY: ValidM=0, MemBeatValid=0.
- Non-memory entries never assert MemBeatValid.
- Loads with MemWriteM=0 drive MemBeatData from WriteDataM anyway; memory ignores it.
- Address arithmetic is unsigned, I bits, wraps modulo 2^I; AddressM itself never changes during a burst.

## Timing
- Reset (reset==0 at falling edge): state EMPTY, k=0, every output 0 (StallE=0, ValidM=0, MemBeatValid=0, all M fields and LoadDataM 0). This applies mid-burst too; no beat is issued on the following cycle.
- ALU entry: captured at edge 0, ValidM=1 from edge 0; with StallM=0 it leaves on the next advancing edge (1-cycle latency, full throughput).
- Memory entry with zero memory wait: capture at edge 0, beats at edges 1..B, HOLD from edge B. Latency is B+1 cycles; StallE is high for B cycles.
- Each MemReady=0 cycle during BEAT adds one cycle.
- Simultaneous HOLD & !StallM & ValidE: the old entry leaves and the new entry is captured on the same edge (no bubble).
- B==1 (P==R): a single beat with MemBeatLast=1 constantly.

## Test plan
- Reset: drive reset=0 mid-burst (R=6, P=2, k=1) → next cycle all outputs 0, state EMPTY, StallE=0.
- ALU stream: 3 back-to-back ValidE ALU ops, StallM=0 → ValidM high 3 consecutive cycles, ALUOutputM matches each, StallE never 1.
- Store: AddressE=0x100, WriteDataE lanes 0..5 = 0x10..0x15, MemReady=1 → beats at addr 0x100/0x102/0x104 with data {0x11,0x10},{0x13,0x12},{0x15,0x14}; MemBeatLast on 3rd beat; StallE high 3 cycles.
- Load with wait: MemtoRegE=1, MemReady low on the 2nd beat for 2 cycles, MemRdata per accepted beat = {0xA1,0xA0},{0xB1,0xB0},{0xC1,0xC0} → LoadDataM = {C1,C0,B1,B0,A1,A0}; ValidM after 5 burst cycles.
- Stall/flush: HOLD with StallM=1 and FlushE=1 → entry held, flush ignored. StallM drops with FlushE=1 → EMPTY, RegWriteM=0.
- Wrap: AddressE=0xFFFFFFFE, store → beat addresses 0xFFFFFFFE, 0x00000000, 0x00000002.
